// File: rtl/sparse_pkg.sv
// Shared definitions for the sparse operand interface: lane geometry and packer FSM states.
package sparse_pkg;

    localparam int unsigned LANES   = 16;
    localparam int unsigned DW      = 8;
    localparam int unsigned IW      = $clog2(LANES);
    // Width of one lane slice inside the flat operand word; the dot-product unit slices the same way.
    localparam int unsigned SLICE_W = DW;
    localparam int unsigned VEC_W   = LANES * SLICE_W;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage : sparse_pkg

// File: rtl/sparse_prio_enc.sv
// Lowest-set-bit priority encoder with any-set and exactly-one-set flags.
module sparse_prio_enc
    import sparse_pkg::*;
(
    input  logic [LANES-1:0] mask,
    output logic [IW-1:0]    idx,
    output logic             any_set,
    output logic             one_set
);

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        idx     = '0;
        any_set = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx     = IW'(i);
                any_set = 1'b1;
            end
        end
        one_set = any_set && ((mask & (mask - LANES'(1))) == '0);
    end

endmodule : sparse_prio_enc

// File: rtl/sparse_vector_packer.sv
// Dense 16-lane INT8 vector to (value, index) beat stream; one marker beat for an all-zero vector.
module sparse_vector_packer
    import sparse_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [VEC_W-1:0] in_vec,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DW-1:0]    out_val,
    output logic [IW-1:0]    out_idx,
    output logic             out_last,
    output logic             out_empty,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [LANES-1:0]   rem_q, rem_d;
    logic               empty_q, empty_d;
    logic               run_q;

    logic [SLICE_W-1:0] lanes [LANES];
    logic [LANES-1:0]   nz;
    logic [LANES-1:0]   idx_bit;
    logic [IW-1:0]      enc_idx;
    logic               enc_any;
    logic               enc_one;

    // Lane views of the held vector and non-zero mask of the incoming one.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lanes[g] = vec_q[g*SLICE_W +: SLICE_W];
        assign nz[g]    = |in_vec[g*SLICE_W +: SLICE_W];
    end

    sparse_prio_enc u_prio_enc (
        .mask    (rem_q),
        .idx     (enc_idx),
        .any_set (enc_any),
        .one_set (enc_one)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            rem_q   <= '0;
            empty_q <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            rem_q   <= rem_d;
            empty_q <= empty_d;
            run_q   <= 1'b1;
        end
    end

    // Next-state, beat decode and handshake.
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        rem_d     = rem_q;
        empty_d   = empty_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_val   = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        out_empty = 1'b0;
        idx_bit   = '0;
        idx_bit[enc_idx] = 1'b1;

        case (state_q)
            IDLE: begin
                in_ready = run_q;
            end
            EMIT: begin
                out_valid = 1'b1;
                if (empty_q) begin
                    out_last  = 1'b1;
                    out_empty = 1'b1;
                end else if (enc_any) begin
                    out_idx  = enc_idx;
                    out_val  = lanes[enc_idx];
                    out_last = enc_one;
                end
                in_ready = run_q & out_last & out_ready;
                if (out_ready) begin
                    rem_d = rem_q & ~idx_bit;
                    if (out_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new vector overrides the drain-to-idle of a finishing one.
        if (in_valid && in_ready) begin
            vec_d   = in_vec;
            rem_d   = nz;
            empty_d = (nz == '0);
            state_d = EMIT;
        end
    end

endmodule : sparse_vector_packer

// File: doc/sparse_vector_packer.md
# sparse_vector_packer

Compresses a dense 16-lane INT8 vector into a stream of (value, index) beats, one per non-zero lane, in ascending lane order. It is the encoding end of the sparse interface: it sits upstream of the sparse dot-product unit and turns the flat 128-bit operand packing into the compressed form that unit consumes. A valid/ready handshake is used on both sides. An all-zero vector still produces exactly one marker beat, so every accepted vector yields a terminated packet.

## Interface
- LANES, 16, number of lanes per dense vector
- DW, 8, lane data width in bits
- IW, $clog2(LANES) = 4, lane index width

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- in_vec  in  LANES*DW  dense vector; lane i occupies bits [DW*i+DW-1 : DW*i]
- in_valid  in  1  in_vec is valid
- in_ready  out  1  packer can accept a vector this cycle
- out_val  out  DW  value of the current non-zero lane
- out_idx  out  IW  lane number of out_val
- out_last  out  1  current beat is the final beat of its vector
- out_empty  out  1  vector was all-zero; the beat is a marker only
- out_valid  out  1  output beat is valid
- out_ready  in  1  downstream accepts the beat

## Operation
- Two-state FSM:
  - IDLE: no vector held.
  - EMIT: a vector is held with a remaining-lane mask `rem`.
- Accepting a vector (in_valid & in_ready):
  - Register in_vec into `vec`.
  - Set rem[i] = (lane i != 0).
  - Set the empty flag = (nonzero mask == 0).
  - Go to EMIT.
- In EMIT, out_valid = 1.
  - Normal beat: out_idx = position of the lowest set bit of rem; out_val = vec lane out_idx.
  - out_last = 1 when rem has exactly one bit set.
  - Empty vector: out_val = 0, out_idx = 0, out_last = 1, out_empty = 1.
- Beat transfer (out_valid & out_ready):
  - Clear rem[out_idx].
  - If out_last, the vector is done: go to IDLE, or stay in EMIT if a new vector is accepted in the same cycle.
- in_ready = (state == IDLE) | (state == EMIT & out_last & out_ready). This allows back-to-back vectors with no bubble.
- Lane values are treated as raw bit patterns. A value of 8'h80 is non-zero and must be emitted.
- Stall behaviour: while out_valid & !out_ready, out_val, out_idx, out_last and out_empty stay stable.

## Timing
- While rst = 0, or on its assertion at any time, regardless of clk:
  - state = IDLE; vec = 0; rem = 0; empty flag = 0.
  - Resulting outputs: out_valid = 0, out_val = 0, out_idx = 0, out_last = 0, out_empty = 0.
  - in_ready = 0 while rst is low.
- in_ready = 1 from the first clk edge after rst deasserts.
- Reset mid-packet discards the held vector. The stream does not restart.
- Latency: a vector accepted at edge k presents its first beat from edge k until the next transfer.
- Packet length:
  - A vector with N non-zero lanes takes N transfer cycles (N ≥ 1), or 1 cycle if N = 0.
  - With out_ready held high, sustained throughput is one beat per cycle across vector boundaries.
- The in_ready → out_ready combinational path is permitted. No path from in_valid to out_* is permitted.
- Simultaneous final transfer and new accept: the new vector's first beat appears in the next cycle. Nothing is dropped or duplicated.

## Structure
- Shared package `sparse_pkg` holds:
  - LANES, DW, IW;
  - the FSM state typedef (IDLE, EMIT);
  - a helper constant for the lane slice width, shared with the dot-product unit.
- One sub-module, `sparse_prio_enc`:
  - Input: LANES-bit mask.
  - Outputs: index of the lowest set bit, any-set flag, exactly-one-set flag.
  - Purely combinational.
- The top level contains the FSM, the vec/rem registers and the handshake logic.

## Test plan
- Reset then `in_vec` = 128'h0000_0000_0000_0000_0000_0000_0000_0005, out_ready = 1 → one beat: val 8'h05, idx 0, last 1, empty 0.
- `in_vec` with lane 3 = 8'h11, lane 9 = 8'h80, lane 15 = 8'hFF, rest zero → beats (11,3,0), (80,9,0), (FF,15,1), in that order.
- `in_vec` = 128'h0 → single beat: val 0, idx 0, last 1, empty 1; in_ready returns high on the same edge.
- `in_vec` = all 8'hFF with out_ready toggling 1,0,1,0,…:
  - 16 beats, idx 0..15;
  - outputs stable during each stall;
  - last only on idx 15.
- Two vectors presented back-to-back with out_ready = 1: the second vector's first beat follows the first vector's last beat with no bubble.
- Assert rst during beat 2 of a 3-beat vector:
  - outputs go to 0 immediately;
  - after release, in_ready = 1;
  - the next vector emits correctly from idx of its lowest non-zero lane.
